// File: rtl/edge_pkg.sv
// Shared constants and FSM encoding for the edge-detect UART return path.
package edge_pkg;

    localparam int CLK_FREQ_DFLT = 50_000_000;
    localparam int UART_BPS_DFLT = 9600;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/edge_tx_fifo.sv
// Synchronous show-ahead FIFO; a push while full is taken only when a pop
// happens in the same cycle.
module edge_tx_fifo
    import edge_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/edge_uart_tx.sv
// Buffers binarised Sobel pixels and serialises them as contiguous 8N1 UART
// frames; a sticky flag records any pixel lost to a full buffer.
module edge_uart_tx
    import edge_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DFLT,
    parameter int UART_BPS   = UART_BPS_DFLT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       tx_busy,
    output logic       overflow
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              tx_busy_q, tx_busy_d;
    logic              overflow_q, overflow_d;

    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              bit_end;

    edge_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (pi_flag),
        .pop   (fifo_pop),
        .din   (pi_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    bit_cnt_d = 3'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_dout;
                        bit_cnt_d = 3'd0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Line level and busy are registered from current state, so both lag the FSM by one clock.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        tx_busy_d  = (state_q != IDLE) | (fifo_count != '0);
        overflow_d = overflow_q | (pi_flag & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        shift_q <= shift_d;
    end

    assign tx       = tx_q;
    assign tx_busy  = tx_busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_uart_tx.sv
// Bench for edge_uart_tx: directed scenarios plus random pixel traffic, checked
// against a queue/timing model and a bench-side UART receiver.
module tb_edge_uart_tx;
    import edge_pkg::*;

    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] pi_data   = 8'h00;
    logic       pi_flag   = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       overflow;

    edge_uart_tx #(
        .CLK_FREQ   (1000),
        .UART_BPS   (100),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pi_data   (pi_data),
        .pi_flag   (pi_flag),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .overflow  (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending bytes, whether the line is idle, and the edge at
    // which the current frame ends. A frame starting at edge p shows its start bit at p+1.
    logic [7:0] m_q[$];
    bit         m_idle = 1'b1;
    int         m_end  = 0;
    bit         m_ovf  = 1'b0;
    logic [7:0] exp_b[$];
    int         exp_t[$];

    function automatic void model_step(input bit f, input logic [7:0] d, input int e);
        bit pop_now;
        pop_now = (m_q.size() > 0) && (m_idle || e == m_end);
        if (pop_now) begin
            exp_b.push_back(m_q.pop_front());
            exp_t.push_back(e + 1);
            m_end  = e + FRAME;
            m_idle = 1'b0;
        end else if (!m_idle && e == m_end) begin
            m_idle = 1'b1;
        end
        if (f) begin
            if (m_q.size() < 4) m_q.push_back(d);
            else                m_ovf = 1'b1;
        end
    endfunction

    // Bench UART receiver, sampling mid-bit on falling clock edges.
    logic [7:0] rx_b[$];
    int         rx_t[$];

    task automatic rx_wait(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            if (!sys_rst_n) ab = 1'b1;
        end
    endtask

    initial begin : rx_dec
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n === 1'b1 && tx === 1'b0) begin
                int         t0;
                bit         ab;
                logic [7:0] b;
                logic       s;
                t0 = cyc;
                ab = 1'b0;
                rx_wait(5, ab);
                s = tx;
                for (int i = 0; i < 8; i++) begin
                    rx_wait(CPB, ab);
                    b[i] = tx;
                end
                rx_wait(CPB, ab);
                if (!ab) begin
                    chk("rx_start_bit", {31'd0, s}, 32'd0);
                    chk("rx_stop_bit", {31'd0, tx}, 32'd1);
                    rx_b.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    task automatic cycle(input bit f, input logic [7:0] d);
        bit busy_prev;
        pi_flag   = f;
        pi_data   = d;
        busy_prev = !m_idle || (m_q.size() > 0);
        model_step(f, d, cyc + 1);
        @(negedge sys_clk);
        pi_flag = 1'b0;
        chk("tx_busy", {31'd0, tx_busy}, {31'd0, busy_prev});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((!m_idle || m_q.size() > 0) && k < 3000) begin
            cycle(1'b0, 8'h00);
            k++;
        end
        repeat (3) cycle(1'b0, 8'h00);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, rx_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < rx_b.size(); i++) begin
            chk({tag, "_byte"}, {24'd0, rx_b[i]}, {24'd0, exp_b[i]});
            chk({tag, "_start_edge"}, rx_t[i], exp_t[i]);
        end
        rx_b.delete();
        rx_t.delete();
        exp_b.delete();
        exp_t.delete();
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        pi_flag   = 1'b0;
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        if (!m_idle) begin
            void'(exp_b.pop_back());
            void'(exp_t.pop_back());
        end
        m_q.delete();
        m_idle = 1'b1;
        m_ovf  = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int gap;

        repeat (3) @(negedge sys_clk);
        chk("init_tx", {31'd0, tx}, 32'd1);
        chk("init_busy", {31'd0, tx_busy}, 32'd0);
        chk("init_overflow", {31'd0, overflow}, 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) cycle(1'b0, 8'h00);

        // Single byte: latency and busy release.
        cycle(1'b1, 8'hA5);
        for (int k = 1; k <= 110; k++) begin
            cycle(1'b0, 8'h00);
            if (k == 1)   chk("lat_before_fall", {31'd0, tx}, 32'd1);
            if (k == 2)   chk("lat_fall", {31'd0, tx}, 32'd0);
            if (k == 101) chk("busy_hold", {31'd0, tx_busy}, 32'd1);
            if (k == 102) chk("busy_fall", {31'd0, tx_busy}, 32'd0);
        end
        drain();
        compare("single");

        // Back-to-back frames.
        cycle(1'b1, BLACK);
        cycle(1'b0, 8'h00);
        cycle(1'b1, WHITE);
        drain();
        if (rx_t.size() >= 2) chk("b2b_gap", rx_t[1] - rx_t[0], FRAME);
        chk("b2b_overflow", {31'd0, overflow}, 32'd0);
        compare("b2b");

        // Six consecutive pulses: one in flight, four buffered, one dropped.
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i));
        drain();
        chk("ovf_frames", rx_b.size(), 5);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        compare("ovf");
        do_reset();
        repeat (2) cycle(1'b0, 8'h00);

        // Push into a full FIFO on the edge the stop bit ends.
        n = cyc + 1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i));
        while (cyc + 1 < n + 1 + FRAME) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h1F);
        drain();
        chk("fullpop_frames", rx_b.size(), 6);
        chk("fullpop_overflow", {31'd0, overflow}, 32'd0);
        compare("fullpop");

        // Reset in the middle of a frame.
        cycle(1'b1, 8'h5A);
        repeat (47) cycle(1'b0, 8'h00);
        do_reset();
        repeat (120) cycle(1'b0, 8'h00);
        chk("rst_no_frame", rx_b.size(), 0);
        cycle(1'b1, 8'h3C);
        drain();
        compare("after_rst");

        // Alternating binarised pixel stream at one pixel per frame time.
        for (int i = 0; i < 48; i++) begin
            cycle(1'b1, (i % 2 == 1) ? WHITE : BLACK);
            repeat (FRAME - 1) cycle(1'b0, 8'h00);
        end
        drain();
        chk("sobel_overflow", {31'd0, overflow}, 32'd0);
        compare("sobel");

        // Random pixels with random spacing, including bursts that may overflow.
        for (int i = 0; i < 80; i++) begin
            cycle(1'b1, 8'($urandom));
            gap = int'($urandom_range(130, 0));
            repeat (gap) cycle(1'b0, 8'h00);
        end
        drain();
        compare("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
